// File: rtl/mul_job_sequencer.sv
// Command-queue scheduler for the multiplier datapath: queues {mode, reps} jobs, arms mem_mode,
// gates AS/SA starts on hash_ready, pulses calc_init and repeats each job with a settle gap.
module mul_job_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int REPS_W         = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_mode,
  input  logic [REPS_W-1:0] cmd_reps,
  input  logic              abort,
  input  logic              clear_err,
  input  logic              hash_ready,
  input  logic              mul_done,
  output logic [2:0]        mem_mode,
  output logic              calc_init,
  output logic              busy,
  output logic              job_done,
  output logic              cmd_illegal,
  output logic              err_timeout
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] MODE_AS = 3'd1;
  localparam logic [2:0] MODE_SA = 3'd2;
  localparam logic [2:0] MODE_BS = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_RUN, S_GAP, S_DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        mode_q, mode_n;
  logic [REPS_W-1:0] reps_left, reps_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [2:0]        mem_mode_n;
  logic              calc_n, done_n, err_n;
  logic [AW:0]       wr_ptr, rd_ptr, wr_n, rd_n, count_n;
  logic              push, pop, flush, legal, empty;
  logic [REPS_W-1:0] reps_fix;

  logic [2:0]        mode_mem [FIFO_DEPTH];
  logic [REPS_W-1:0] reps_mem [FIFO_DEPTH];

  assign legal    = (cmd_mode >= MODE_AS) && (cmd_mode <= MODE_BS);
  assign reps_fix = (cmd_reps == '0) ? REPS_W'(1) : cmd_reps;
  assign empty    = (wr_ptr == rd_ptr);
  // A push coinciding with abort is dropped even though the handshake completes.
  assign push     = cmd_valid && cmd_ready && legal && !abort;

  always_ff @(posedge clk) begin
    if (push) begin
      mode_mem[wr_ptr[AW-1:0]] <= cmd_mode;
      reps_mem[wr_ptr[AW-1:0]] <= reps_fix;
    end
  end

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    reps_n     = reps_left;
    to_n       = to_cnt;
    gap_n      = gap_cnt;
    mem_mode_n = mem_mode;
    calc_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = clear_err ? 1'b0 : err_timeout;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !err_timeout) begin
          pop        = 1'b1;
          mode_n     = mode_mem[rd_ptr[AW-1:0]];
          reps_n     = reps_mem[rd_ptr[AW-1:0]];
          mem_mode_n = mode_mem[rd_ptr[AW-1:0]];
          state_n    = S_ARM;
        end
      end
      S_ARM: begin
        if (!(mode_q == MODE_AS || mode_q == MODE_SA) || hash_ready) begin
          calc_n  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        to_n    = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        to_n = to_cnt + TO_W'(1);
        if (mul_done) begin
          reps_n = reps_left - REPS_W'(1);
          gap_n  = GAP_W'(1);
          if (reps_left == REPS_W'(1)) state_n = S_DONE;
          else                         state_n = (GAP_CYCLES > 1) ? S_GAP : S_ARM;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_n      = 1'b1;
          mem_mode_n = 3'd0;
          flush      = 1'b1;
          state_n    = S_IDLE;
        end
      end
      // The ARM cycle that follows also counts as an idle cycle, so GAP lasts GAP_CYCLES-1.
      S_GAP: begin
        if (gap_cnt >= GAP_W'(GAP_CYCLES - 1)) state_n = S_ARM;
        else                                   gap_n   = gap_cnt + GAP_W'(1);
      end
      S_DONE: begin
        done_n     = 1'b1;
        mem_mode_n = 3'd0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n    = S_IDLE;
      mem_mode_n = 3'd0;
      calc_n     = 1'b0;
      done_n     = 1'b0;
      reps_n     = '0;
      pop        = 1'b0;
      flush      = 1'b1;
    end
    if (flush) begin
      wr_n = wr_ptr;
      rd_n = wr_ptr;
    end else begin
      wr_n = wr_ptr + (AW+1)'(push);
      rd_n = rd_ptr + (AW+1)'(pop);
    end
    count_n = wr_n - rd_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= 3'd0;
      reps_left   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_mode    <= 3'd0;
      calc_init   <= 1'b0;
      job_done    <= 1'b0;
      err_timeout <= 1'b0;
      cmd_illegal <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      reps_left   <= reps_n;
      to_cnt      <= to_n;
      gap_cnt     <= gap_n;
      wr_ptr      <= wr_n;
      rd_ptr      <= rd_n;
      mem_mode    <= mem_mode_n;
      calc_init   <= calc_n;
      job_done    <= done_n;
      err_timeout <= err_n;
      cmd_illegal <= cmd_valid && cmd_ready && !legal;
      cmd_ready   <= !count_n[AW] && !err_n;
      busy        <= (state_n != S_IDLE) || (wr_n != rd_n);
    end
  end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Directed bench for mul_job_sequencer: single job, repeats, hash gating, queue full/order,
// illegal commands, timeout and abort.
module tb_mul_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_mode = 3'd0;
  logic [15:0] cmd_reps = 16'd0;
  logic        abort = 1'b0;
  logic        clear_err = 1'b0;
  logic        hash_ready = 1'b0;
  logic        mul_done = 1'b0;
  logic [2:0]  mem_mode;
  logic        calc_init, busy, job_done, cmd_illegal, err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mul_job_sequencer #(.FIFO_DEPTH(4), .REPS_W(16), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_reps(cmd_reps), .abort(abort), .clear_err(clear_err),
    .hash_ready(hash_ready), .mul_done(mul_done), .mem_mode(mem_mode), .calc_init(calc_init),
    .busy(busy), .job_done(job_done), .cmd_illegal(cmd_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [2:0] m, input logic [15:0] r);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_reps  = r;
    step();
    cmd_valid = 1'b0;
    cmd_mode  = 3'd0;
    cmd_reps  = 16'd0;
  endtask

  task automatic pulse_done();
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
  endtask

  task automatic wait_calc(input int lim, output bit seen);
    int n = 0;
    while (calc_init !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    seen = (calc_init === 1'b1);
  endtask

  task automatic wait_job(input int lim, output bit seen);
    int n = 0;
    while (job_done !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    seen = (job_done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({cmd_ready, mem_mode, calc_init, busy, job_done, cmd_illegal, err_timeout} !== 9'b1_000_00000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {cmd_ready, mem_mode, calc_init, busy, job_done, cmd_illegal, err_timeout}, 9'b1_000_00000);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_as();
    int c;
    bit bad = 0;
    hash_ready = 1'b1;
    push(3'd1, 16'd1);
    checks++;
    if (mem_mode !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL as_t1: mem_mode=%0d busy=%b expected 0/1", mem_mode, busy);
    end
    step();
    checks++;
    if (mem_mode !== 3'd1 || calc_init !== 1'b0) begin
      failures++;
      $display("FAIL as_t2_mode: mem_mode=%0d calc_init=%b expected 1/0", mem_mode, calc_init);
    end
    step();
    checks++;
    if (calc_init !== 1'b1) begin
      failures++;
      $display("FAIL as_t3_calc_init: got %b expected 1", calc_init);
    end
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      step();
      if (calc_init !== 1'b0 || mem_mode !== 3'd1 || job_done !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL as_run_hold: unexpected calc_init/mem_mode/job_done while running, got 1 expected 0");
    end
    pulse_done();
    checks++;
    if (job_done !== 1'b0) begin
      failures++;
      $display("FAIL as_done_early: job_done=%b expected 0", job_done);
    end
    step();
    checks++;
    if (job_done !== 1'b1 || mem_mode !== 3'd0 || cyc != c + 12) begin
      failures++;
      $display("FAIL as_job_done: job_done=%b mem_mode=%0d expected 1/0", job_done, mem_mode);
    end
    step();
    checks++;
    if (job_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL as_idle_after: job_done=%b busy=%b expected 0/0", job_done, busy);
    end
  endtask

  task automatic test_repeat_sb();
    bit seen;
    bit mode_ok = 1;
    bit gap_ok = 1;
    int dcyc = 0;
    int calcs = 0;
    int dones = 0;
    push(3'd3, 16'd3);
    for (int rep = 0; rep < 3; rep++) begin
      wait_calc(20, seen);
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL sb_calc_seen: rep %0d calc_init got 0 expected 1", rep);
      end
      if (rep > 0 && cyc - dcyc != 3) gap_ok = 0;
      if (mem_mode !== 3'd3) mode_ok = 0;
      step(); step(); step();
      dcyc = cyc;
      pulse_done();
      if (rep < 2 && mem_mode !== 3'd3) mode_ok = 0;
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (job_done === 1'b1) dones++;
      if (calc_init === 1'b1) calcs++;
    end
    checks++;
    if (!gap_ok) begin
      failures++;
      $display("FAIL sb_gap_spacing: calc_init spacing after mul_done wrong, expected 3 cycles");
    end
    checks++;
    if (!mode_ok) begin
      failures++;
      $display("FAIL sb_mode_held: mem_mode not held at 3 for whole job");
    end
    checks++;
    if (dones != 1 || calcs != 0) begin
      failures++;
      $display("FAIL sb_tail: job_done pulses=%0d extra calc_init=%0d expected 1/0", dones, calcs);
    end
  endtask

  task automatic test_hash_wait();
    bit bad = 0;
    bit seen;
    hash_ready = 1'b0;
    push(3'd2, 16'd1);
    step();
    checks++;
    if (mem_mode !== 3'd2) begin
      failures++;
      $display("FAIL sa_mode: got %0d expected 2", mem_mode);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (calc_init !== 1'b0 || mem_mode !== 3'd2) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL sa_hash_stall: calc_init fired or mode dropped without hash_ready, got 1 expected 0");
    end
    hash_ready = 1'b1;
    step();
    checks++;
    if (calc_init !== 1'b1) begin
      failures++;
      $display("FAIL sa_hash_release: calc_init=%b expected 1", calc_init);
    end
    step(); step();
    pulse_done();
    wait_job(6, seen);
    step();
    hash_ready = 1'b0;
    push(3'd3, 16'd1);
    step(); step();
    checks++;
    if (calc_init !== 1'b1 || mem_mode !== 3'd3) begin
      failures++;
      $display("FAIL sb_no_hash: calc_init=%b mem_mode=%0d expected 1/3", calc_init, mem_mode);
    end
    step(); step();
    pulse_done();
    wait_job(6, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL sb_no_hash_done: job_done got 0 expected 1");
    end
    step();
    hash_ready = 1'b1;
  endtask

  task automatic test_queue_full();
    logic [2:0] q_modes [4] = '{3'd3, 3'd2, 3'd4, 3'd1};
    logic [2:0] exp_modes [5] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd1};
    bit ready_ok = 1;
    bit order_ok = 1;
    bit done_ok = 1;
    bit bad = 0;
    bit seen;
    hash_ready = 1'b0;
    push(3'd1, 16'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready !== 1'b1) ready_ok = 0;
      push(q_modes[i], 16'd1);
    end
    checks++;
    if (!ready_ok) begin
      failures++;
      $display("FAIL q_ready_while_filling: cmd_ready dropped early, expected 1");
    end
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL q_full: cmd_ready=%b busy=%b expected 0/1", cmd_ready, busy);
    end
    push(3'd2, 16'd1);
    hash_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_calc(30, seen);
      if (!seen || mem_mode !== exp_modes[j]) order_ok = 0;
      step(); step();
      pulse_done();
      wait_job(6, seen);
      if (!seen || mem_mode !== 3'd0) done_ok = 0;
    end
    step(); step(); step();
    checks++;
    if (!order_ok) begin
      failures++;
      $display("FAIL q_fifo_order: job modes not in FIFO order 1,3,2,4,1");
    end
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL q_job_done: a job_done missing or mem_mode not 0 on completion");
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL q_fifth_dropped: busy=%b expected 0", busy);
    end
    push(3'd0, 16'd1);
    checks++;
    if (cmd_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_pulse: cmd_illegal=%b expected 1", cmd_illegal);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_illegal !== 1'b0 || calc_init !== 1'b0 || mem_mode !== 3'd0 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL illegal_no_job: illegal command started a job or pulse repeated, got 1 expected 0");
    end
  endtask

  task automatic test_timeout();
    int c;
    bit seen;
    bit bad = 0;
    hash_ready = 1'b1;
    push(3'd3, 16'd1);
    wait_calc(10, seen);
    c = cyc;
    push(3'd1, 16'd1);
    push(3'd4, 16'd1);
    while (cyc < c + 16) step();
    checks++;
    if (err_timeout !== 1'b0 || mem_mode !== 3'd3) begin
      failures++;
      $display("FAIL to_early: err_timeout=%b mem_mode=%0d expected 0/3", err_timeout, mem_mode);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || mem_mode !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL to_fire: err=%b mem_mode=%0d busy=%b cmd_ready=%b expected 1/0/0/0",
               err_timeout, mem_mode, busy, cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (calc_init !== 1'b0 || err_timeout !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL to_sticky_flush: flag dropped or flushed job ran, got 1 expected 0");
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL to_clear: err=%b cmd_ready=%b expected 0/1", err_timeout, cmd_ready);
    end
  endtask

  task automatic test_abort();
    bit seen;
    bit bad = 0;
    push(3'd3, 16'd1);
    wait_calc(10, seen);
    push(3'd1, 16'd1);
    push(3'd2, 16'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (mem_mode !== 3'd0 || calc_init !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_run: mem_mode=%0d calc_init=%b busy=%b expected 0/0/0", mem_mode, calc_init, busy);
    end
    pulse_done();
    for (int i = 0; i < 6; i++) begin
      if (job_done !== 1'b0 || calc_init !== 1'b0 || busy !== 1'b0) bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_run_after: job_done/calc_init/busy seen after abort, got 1 expected 0");
    end
    bad = 0;
    push(3'd3, 16'd3);
    wait_calc(10, seen);
    push(3'd4, 16'd1);
    push(3'd1, 16'd1);
    pulse_done();
    checks++;
    if (mem_mode !== 3'd3) begin
      failures++;
      $display("FAIL abort_gap_pre: mem_mode=%0d expected 3", mem_mode);
    end
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 3'd2;
    cmd_reps = 16'd1;
    step();
    abort = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 3'd0;
    checks++;
    if (mem_mode !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_gap: mem_mode=%0d busy=%b cmd_ready=%b expected 0/0/1", mem_mode, busy, cmd_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (job_done !== 1'b0 || calc_init !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_gap_after: activity after abort, got 1 expected 0");
    end
  endtask

  initial begin
    test_reset();
    test_single_as();
    test_repeat_sb();
    test_hash_wait();
    test_queue_full();
    test_timeout();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
